// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that picks one FU per cycle for the common data bus and
// registers its payload onto cdb with a one-hot grant and a saturating broadcast count.
`ifndef NUM_CDBBITS
`define NUM_CDBBITS 33
`endif
`ifndef CDB_ON_FIELD
`define CDB_ON_FIELD (`NUM_CDBBITS-1)
`endif

module cdb_arb_lane #(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 sel,
  input  logic [PAYLOAD_W-1:0] payload,
  output logic [PAYLOAD_W-1:0] gated
);
  assign gated = sel ? payload : '0;
endmodule

module cdb_arbiter #(
  parameter int PAYLOAD_W = `NUM_CDBBITS-1,
  parameter int NUM_FU    = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [NUM_FU-1:0]           req,
  input  logic [NUM_FU*PAYLOAD_W-1:0] payload,
  output logic [PAYLOAD_W:0]          cdb,
  output logic [NUM_FU-1:0]           grant,
  output logic [15:0]                 bcast_count
);
  localparam int IDX_W = 3;

  logic [IDX_W-1:0]                    ptr;
  logic [NUM_FU-1:0]                   elig;
  logic [2*NUM_FU-1:0]                 elig2;
  logic                                found;
  logic [IDX_W-1:0]                    off;
  logic [IDX_W:0]                      sum;
  logic [IDX_W-1:0]                    win;
  logic [NUM_FU-1:0]                   win_oh;
  logic [IDX_W-1:0]                    ptr_nxt;
  logic [NUM_FU-1:0][PAYLOAD_W-1:0]    gated;
  logic [PAYLOAD_W-1:0]                win_pl;

  // Rotate the eligible set so the pointer lands at bit 0, then take the first set bit.
  always_comb begin
    elig  = req & ~grant;
    elig2 = {elig, elig} >> ptr;
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!found && elig2[k]) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(NUM_FU)) sum = sum - (IDX_W+1)'(NUM_FU);
    win     = sum[IDX_W-1:0];
    win_oh  = found ? (NUM_FU'(1) << win) : '0;
    ptr_nxt = (win == IDX_W'(NUM_FU-1)) ? '0 : win + 1'b1;
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_lane
    cdb_arb_lane #(.PAYLOAD_W(PAYLOAD_W)) u_lane (
      .sel     (win_oh[g]),
      .payload (payload[g*PAYLOAD_W +: PAYLOAD_W]),
      .gated   (gated[g])
    );
  end

  always_comb begin
    win_pl = '0;
    for (int k = 0; k < NUM_FU; k++) win_pl = win_pl | gated[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb         <= '0;
      grant       <= '0;
      ptr         <= '0;
      bcast_count <= '0;
    end else if (flush) begin
      cdb   <= '0;
      grant <= '0;
    end else if (found) begin
      cdb   <= {1'b1, win_pl};
      grant <= win_oh;
      ptr   <= ptr_nxt;
      if (bcast_count != 16'hFFFF) bcast_count <= bcast_count + 16'd1;
    end else begin
      cdb   <= '0;
      grant <= '0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter: a rule-level round-robin model is checked every
// cycle, plus directed literal checks for reset, rotation, wrap, flush and saturation.
module tb_cdb_arbiter;
  localparam int NF = 5;
  localparam int PW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [NF-1:0]     req = '0;
  logic [NF*PW-1:0]  payload;
  logic [PW:0]       cdb;
  logic [NF-1:0]     grant;
  logic [15:0]       bcast_count;
  logic [PW-1:0]     pl_fu [NF];

  int n_checks = 0;
  int n_fail   = 0;

  cdb_arbiter #(.PAYLOAD_W(PW), .NUM_FU(NF)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req(req), .payload(payload),
    .cdb(cdb), .grant(grant), .bcast_count(bcast_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    payload = '0;
    for (int i = 0; i < NF; i++) payload[i*PW +: PW] = pl_fu[i];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: scan from the pointer, skip the FU broadcast last cycle.
  logic              m_valid = 1'b0;
  int                m_ptr, m_last, w, fi;
  int unsigned       m_cnt;
  int                waits [NF];
  logic [NF-1:0]     s_req;
  logic              s_flush, s_rst;
  logic [NF*PW-1:0]  s_pl;
  logic [PW:0]       exp_cdb;
  logic [NF-1:0]     exp_grant;

  always @(posedge clk) begin
    s_req = req; s_flush = flush; s_rst = rst; s_pl = payload;
    w = -1;
    if (s_rst) begin
      m_valid = 1'b1; m_ptr = 0; m_last = -1; m_cnt = 0;
      exp_cdb = '0; exp_grant = '0;
      for (int i = 0; i < NF; i++) waits[i] = 0;
    end else if (s_flush) begin
      m_last = -1; exp_cdb = '0; exp_grant = '0;
    end else begin
      for (int k = 0; k < NF; k++) begin
        fi = (m_ptr + k) % NF;
        if (w < 0 && s_req[fi] && fi != m_last) w = fi;
      end
      if (w >= 0) begin
        exp_grant = '0; exp_grant[w] = 1'b1;
        exp_cdb   = {1'b1, s_pl[w*PW +: PW]};
        m_ptr     = (w + 1) % NF;
        m_last    = w;
        if (m_cnt != 32'd65535) m_cnt++;
      end else begin
        exp_grant = '0; exp_cdb = '0; m_last = -1;
      end
    end
    #1;
    if (m_valid) begin
      chk("cdb", 64'(cdb), 64'(exp_cdb));
      chk("grant", 64'(grant), 64'(exp_grant));
      chk("bcast_count", 64'(bcast_count), 64'(m_cnt));
      chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
      chk("on_eq_or_grant", 64'(cdb[PW]), 64'(|grant));
      if (!s_rst && !s_flush && w >= 0) begin
        for (int i = 0; i < NF; i++) begin
          if (!s_req[i] || i == w) waits[i] = 0;
          else begin
            waits[i]++;
            chk($sformatf("fairness_fu%0d", i), 64'(waits[i] <= NF-1), 64'd1);
          end
        end
      end else if (!s_rst && !s_flush) begin
        for (int i = 0; i < NF; i++) if (!s_req[i]) waits[i] = 0;
      end
    end
  end

  task automatic step(input logic [NF-1:0] r, input logic f, input logic rs);
    @(negedge clk);
    req = r; flush = f; rst = rs;
    @(posedge clk);
    #2;
  endtask

  logic [NF-1:0] rq;
  logic          tog;
  int            exp_seq [6] = '{1, 2, 4, 8, 16, 1};

  initial begin
    for (int i = 0; i < NF; i++) pl_fu[i] = 32'h1000_0000 + i;
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    chk("reset_cdb", 64'(cdb), 64'd0);
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_count", 64'(bcast_count), 64'd0);

    // single load request after reset
    pl_fu[2] = 32'hCAFE_0002;
    step(5'b00100, 1'b0, 1'b0);
    chk("load_cdb", 64'(cdb), {31'd0, 1'b1, 32'hCAFE_0002});
    chk("load_grant", 64'(grant), 64'b00100);
    chk("load_count", 64'(bcast_count), 64'd1);
    step('0, 1'b0, 1'b0);
    chk("idle_grant", 64'(grant), 64'd0);

    // pointer now at 3: FU0 wins by wrap, FU2 follows
    step(5'b00101, 1'b0, 1'b0);
    chk("wrap_grant0", 64'(grant), 64'b00001);
    step(5'b00100, 1'b0, 1'b0);
    chk("wrap_grant2", 64'(grant), 64'b00100);
    step('0, 1'b0, 1'b0);

    // all requesting after reset rotates from FU0
    step('0, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step(5'b11111, 1'b0, 1'b0);
      chk($sformatf("rotate_%0d", c), 64'(grant), 64'(exp_seq[c]));
    end
    chk("rotate_count", 64'(bcast_count), 64'd6);

    // flush drops the sampled request, next cycle grants it
    step('0, 1'b0, 1'b0);
    pl_fu[3] = 32'hBEEF_0003;
    step(5'b01000, 1'b1, 1'b0);
    chk("flush_cdb", 64'(cdb), 64'd0);
    chk("flush_grant", 64'(grant), 64'd0);
    step(5'b01000, 1'b0, 1'b0);
    chk("post_flush_grant", 64'(grant), 64'b01000);
    chk("post_flush_cdb", 64'(cdb), {31'd0, 1'b1, 32'hBEEF_0003});
    step('0, 1'b0, 1'b0);

    // saturation: alternating single requests broadcast every cycle
    tog = 1'b0;
    while (m_cnt < 32'hFFFE) begin
      step(tog ? 5'b00010 : 5'b00001, 1'b0, 1'b0);
      tog = ~tog;
    end
    chk("count_fffe", 64'(bcast_count), 64'hFFFE);
    for (int c = 0; c < 3; c++) begin
      step(tog ? 5'b00010 : 5'b00001, 1'b0, 1'b0);
      tog = ~tog;
      chk($sformatf("count_sat_%0d", c), 64'(bcast_count), c == 0 ? 64'hFFFF : 64'hFFFF);
    end
    step('0, 1'b1, 1'b0);
    chk("count_kept_by_flush", 64'(bcast_count), 64'hFFFF);

    // random requesters that hold until granted
    rq = '0;
    for (int c = 0; c < 10000; c++) begin
      logic f, rs;
      @(negedge clk);
      rs = ($urandom_range(0, 99) < 1);
      f  = ($urandom_range(0, 99) < 4);
      for (int i = 0; i < NF; i++) begin
        if (rq[i] && grant[i]) rq[i] = 1'b0;
        else if (!rq[i] && $urandom_range(0, 99) < 30) begin
          rq[i] = 1'b1;
          pl_fu[i] = $urandom;
        end
      end
      if (rs) rq = '0;
      req = rq; flush = f; rst = rs;
    end
    @(negedge clk);
    req = '0; flush = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter PAYLOAD_W, default `NUM_CDBBITS-1, width of one FU broadcast payload (FU tag, RS one-hot, data) without the on bit.
REQ-002 Parameter NUM_FU, default 5, number of requesting FUs; index 0 ALU, 1 jump, 2 load, 3 mul, 4 div.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  pipeline flush; discards pending and registered broadcasts.
REQ-006 req  input  NUM_FU  per-FU CDB request (bit i = FU i).
REQ-007 payload  input  NUM_FU*PAYLOAD_W  per-FU payload; FU i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
REQ-008 cdb  output  PAYLOAD_W+1  registered broadcast bus {on, payload}; on at MSB (`CDB_ON_FIELD).
REQ-009 grant  output  NUM_FU  registered one-hot; bit i high in the cycle FU i's payload is on cdb.
REQ-010 bcast_count  output  16  saturating count of cycles with cdb on bit = 1.

Function
REQ-011 Arbitration is evaluated combinationally from req, the round-robin pointer and the last-grant mask; results are registered into cdb/grant at posedge clk, giving 1-cycle latency from sampled req to broadcast.
REQ-012 Eligible set = req & ~grant; the FU broadcast in the current cycle is never eligible for the next cycle, so a unit whose request drops only at the next negedge is never broadcast twice.
REQ-013 Winner = first eligible FU at or after pointer ptr, scanning upward with wrap from NUM_FU-1 to 0.
REQ-014 ptr is a 3-bit register; after granting FU i it becomes (i+1) mod NUM_FU; it holds when nothing is granted.
REQ-015 With an eligible winner: cdb <= {1'b1, payload of winner}, grant <= one-hot(winner).
REQ-016 With no eligible requester: cdb <= 0 (on bit and payload all zero), grant <= 0.
REQ-017 The handshake is implicit: a requester holds req and payload stable until it sees its own grant bit or its FU tag on cdb with on=1, and deasserts req before the next posedge; the arbiter does not check the payload FU tag against the index.
REQ-018 At most one grant bit is high in any cycle; cdb on bit equals |grant at all times.
REQ-019 flush = 1 at a posedge: cdb <= 0, grant <= 0, ptr holds, and req sampled in that cycle is ignored; arbitration resumes on the first posedge with flush = 0.
REQ-020 flush and rst together: rst dominates.
REQ-021 bcast_count increments by 1 on every posedge where the on bit being registered is 1; it saturates at 16'hFFFF without wrapping; flush does not clear it.
REQ-022 No request can wait more than NUM_FU-1 grants to other FUs while it stays asserted (fairness bound).

Reset
REQ-023 rst = 1 at posedge: cdb = 0, grant = 0, ptr = 0, bcast_count = 0, all from the next cycle on.
REQ-024 rst asserted mid-broadcast clears cdb in the same clock edge; a requester must re-request after reset.
REQ-025 First arbitration after reset gives FU 0 highest priority.

Verification
REQ-026 After reset, req=5'b00100, load payload P -> next cycle cdb={1,P}, grant=5'b00100, ptr=3, bcast_count=1.
REQ-027 After reset, req=5'b11111 held constant -> grants follow 00001, 00010, 00100, 01000, 10000, 00001 on consecutive cycles (REQ-012 masks the repeat).
REQ-028 ptr=3, req=5'b00101 -> grant 00001 (wrap), then 00100; FU 2 waits exactly one grant.
REQ-029 req=5'b01000 with flush=1 for one cycle -> cdb=0, grant=0 that cycle; with req still high and flush=0 -> grant=01000 next cycle.
REQ-030 Preload bcast_count to 16'hFFFE via continuous single requests -> after two further broadcasts it reads 16'hFFFF and stays there.
REQ-031 Random req/flush/rst stimulus, 10k cycles -> grant always one-hot or zero, cdb on bit == |grant, fairness bound REQ-022 never violated.
